// File: rtl/fft64_stage_ctrl.sv
// Stage sequencer for the 64-point FFT core: frames the 8-beat column load, runs two
// radix-8 passes over ping-pong banks 0/1, then drains columns downstream with valid/ready.
module fft64_stage_ctrl #(
  parameter int PIPE_LAT = 3,
  parameter int N_COL    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_start,
  input  logic       out_ready,
  output logic       load_en,
  output logic       stage_issue,
  output logic       stage_id,
  output logic [2:0] col_idx,
  output logic [2:0] tw_step,
  output logic       wb_valid,
  output logic [2:0] wb_col,
  output logic       rd_bank,
  output logic       wr_bank,
  output logic       dout_valid,
  output logic       frame_done,
  output logic       busy,
  output logic       load_err,
  output logic       frame_drop
);

  typedef enum logic [2:0] {IDLE, LOAD, S1, S2, OUT} state_t;

  // The counter is one bit wider than a column index so it can also count the drain cycles.
  localparam logic [3:0] LAST_BEAT = 4'(N_COL - 1);
  localparam logic [3:0] N_BEAT    = 4'(N_COL);
  localparam logic [3:0] PASS_LAST = 4'(N_COL + PIPE_LAT - 1);

  state_t     state, next_state;
  logic [3:0] cnt, cnt_nxt;
  logic       in_start_q;
  logic       in_rise;

  logic [PIPE_LAT-1:0]      issue_sr;
  logic [PIPE_LAT-1:0][2:0] col_sr;

  assign in_rise = in_start & ~in_start_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      in_start_q <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_nxt;
      in_start_q <= in_start;
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    next_state  = state;
    cnt_nxt     = cnt;
    load_en     = 1'b0;
    stage_issue = 1'b0;
    stage_id    = 1'b0;
    col_idx     = '0;
    tw_step     = '0;
    rd_bank     = 1'b0;
    wr_bank     = 1'b0;
    dout_valid  = 1'b0;
    frame_done  = 1'b0;
    load_err    = 1'b0;
    frame_drop  = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) begin
          load_en    = 1'b1;
          next_state = LOAD;
          cnt_nxt    = 4'd1;
        end
      end
      LOAD: begin
        col_idx = cnt[2:0];
        load_en = in_start;
        if (!in_start) begin
          load_err   = 1'b1;
          next_state = IDLE;
          cnt_nxt    = '0;
        end else if (cnt == LAST_BEAT) begin
          next_state = S1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S1, S2: begin
        stage_id   = (state == S2);
        rd_bank    = (state == S2);
        wr_bank    = (state == S1);
        frame_drop = in_rise;
        if (cnt < N_BEAT) begin
          stage_issue = 1'b1;
          col_idx     = cnt[2:0];
          tw_step     = (state == S1) ? cnt[2:0] : 3'd0;
        end
        // Drain cycles let the last butterfly result land before the banks swap roles.
        if (cnt == PASS_LAST) begin
          next_state = (state == S1) ? S2 : OUT;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      OUT: begin
        dout_valid = 1'b1;
        col_idx    = cnt[2:0];
        frame_drop = in_rise;
        if (out_ready) begin
          if (cnt == LAST_BEAT) begin
            frame_done = 1'b1;
            next_state = IDLE;
            cnt_nxt    = '0;
            // A start on the final handshake begins the next frame without an IDLE bubble.
            if (in_start) begin
              load_en    = 1'b1;
              col_idx    = '0;
              frame_drop = 1'b0;
              next_state = LOAD;
              cnt_nxt    = 4'd1;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: begin
        next_state = IDLE;
        cnt_nxt    = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: the write-back shift pipe is reset because its contents drive strobes straight out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_sr <= '0;
      col_sr   <= '0;
    end else if (next_state == IDLE) begin
      issue_sr <= '0;
      col_sr   <= '0;
    end else begin
      issue_sr[0] <= stage_issue;
      col_sr[0]   <= stage_issue ? col_idx : 3'd0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        issue_sr[i] <= issue_sr[i-1];
        col_sr[i]   <= col_sr[i-1];
      end
    end
  end

  assign wb_valid = issue_sr[PIPE_LAT-1];
  assign wb_col   = col_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_fft64_stage_ctrl.sv
// Scoreboard bench for fft64_stage_ctrl: expected strobe timings are queued from the
// frame timeline when stimulus is applied and popped as the DUT raises each strobe.
module tb_fft64_stage_ctrl;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_start = 1'b0;
  logic       out_ready = 1'b0;
  logic       load_en, stage_issue, stage_id, wb_valid, rd_bank, wr_bank;
  logic       dout_valid, frame_done, busy, load_err, frame_drop;
  logic [2:0] col_idx, tw_step, wb_col;
  logic [19:0] all_outs;

  fft64_stage_ctrl #(.PIPE_LAT(L), .N_COL(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .out_ready(out_ready),
    .load_en(load_en), .stage_issue(stage_issue), .stage_id(stage_id),
    .col_idx(col_idx), .tw_step(tw_step), .wb_valid(wb_valid), .wb_col(wb_col),
    .rd_bank(rd_bank), .wr_bank(wr_bank), .dout_valid(dout_valid),
    .frame_done(frame_done), .busy(busy), .load_err(load_err), .frame_drop(frame_drop)
  );

  assign all_outs = {load_en, stage_issue, stage_id, col_idx, tw_step, wb_valid, wb_col,
                     rd_bank, wr_bank, dout_valid, frame_done, busy, load_err, frame_drop};

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [2:0] col;
    logic [2:0] tw;
    logic     sid;
  } exp_t;

  exp_t load_q[$], issue_q[$], wb_q[$], out_q[$];

  int  checks = 0, errors = 0;
  int  cyc = 0, t0 = 0;
  bit  ready_toggle = 1'b0;
  int  n_err = 0, err_cyc = -1, n_drop = 0, drop_cyc = -1, n_done = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int c, int col, int tw, bit sid);
    exp_t e;
    e.cyc = c;
    e.col = 3'(col);
    e.tw  = 3'(tw);
    e.sid = sid;
    return e;
  endfunction

  // Expected timeline of one frame whose first load beat is cycle t.
  task automatic push_frame(input int t, input int nload, input int ostep);
    for (int k = 0; k < nload; k++) load_q.push_back(mk(t + k, k, 0, 0));
    if (nload == 8) begin
      for (int k = 0; k < 8; k++) issue_q.push_back(mk(t + 8 + k, k, k, 0));
      for (int k = 0; k < 8; k++) issue_q.push_back(mk(t + 16 + L + k, k, 0, 1));
      for (int k = 0; k < 8; k++) wb_q.push_back(mk(t + 8 + L + k, k, 0, 0));
      for (int k = 0; k < 8; k++) wb_q.push_back(mk(t + 16 + 2 * L + k, k, 0, 1));
      for (int k = 0; k < 8; k++) out_q.push_back(mk(t + 24 + 2 * L + ostep * k, k, 0, 0));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (load_en) begin
        if (load_q.size() == 0) check("load_unexpected", 1, 0);
        else begin
          e = load_q.pop_front();
          check("load_cyc", cyc, e.cyc);
          check("load_col", col_idx, e.col);
        end
      end
      if (stage_issue) begin
        if (issue_q.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          e = issue_q.pop_front();
          check("issue_cyc", cyc, e.cyc);
          check("issue_col", col_idx, e.col);
          check("issue_tw", tw_step, e.tw);
          check("issue_sid", stage_id, e.sid);
          check("issue_rd_bank", rd_bank, e.sid);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          e = wb_q.pop_front();
          check("wb_cyc", cyc, e.cyc);
          check("wb_col", wb_col, e.col);
          check("wb_wr_bank", wr_bank, !e.sid);
          check("wb_sid", stage_id, e.sid);
        end
      end
      if (dout_valid) begin
        if (out_q.size() == 0) check("out_unexpected", 1, 0);
        else if (out_ready) begin
          e = out_q.pop_front();
          check("out_cyc", cyc, e.cyc);
          // On a back-to-back restart col_idx carries the new load column instead.
          if (!load_en) check("out_col", col_idx, e.col);
          check("out_frame_done", frame_done, e.col == 3'd7);
          check("out_rd_bank", rd_bank, 0);
        end else begin
          check("out_hold_col", col_idx, out_q[0].col);
          check("out_hold_done", frame_done, 0);
        end
      end
      if (frame_done) n_done++;
      if (load_err) begin n_err++; err_cyc = cyc; end
      if (frame_drop) begin n_drop++; drop_cyc = cyc; end
    end
  end

  task automatic step(input logic start);
    @(posedge clk);
    #1;
    in_start  = start;
    out_ready = ready_toggle ? ((cyc - t0) % 2 == 0) : 1'b1;
  endtask

  // in_start is high for offsets [0,in_len) and [a,b); 'second' queues a frame starting at a.
  task automatic frame(input int in_len, input int a, input int b, input bit second,
                       input int ostep, input int total);
    for (int off = 0; off < total; off++) begin
      step((off < in_len) || (off >= a && off < b));
      if (off == 0) begin
        t0 = cyc;
        push_frame(t0, (in_len < 8) ? in_len : 8, ostep);
      end
      if (second && off == a) push_frame(cyc, 8, 1);
    end
  endtask

  task automatic expect_drained(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_queues_empty"}, load_q.size() + issue_q.size() + wb_q.size() + out_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int done0, drop0, err0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step(1'b0);

    // Nominal frame, downstream always ready.
    done0 = n_done;
    drop0 = n_drop;
    frame(8, 0, 0, 1'b0, 1, 40);
    expect_drained("nominal");
    check("nominal_done_count", n_done - done0, 1);
    check("nominal_no_drop", n_drop - drop0, 0);

    // Downstream ready toggling 1,0.
    ready_toggle = 1'b1;
    done0 = n_done;
    frame(8, 0, 0, 1'b0, 2, 48);
    ready_toggle = 1'b0;
    expect_drained("toggle");
    check("toggle_done_count", n_done - done0, 1);

    // Short load: in_start high 5 cycles.
    err0 = n_err;
    frame(5, 0, 0, 1'b0, 1, 7);
    @(negedge clk);
    #1;
    check("short_busy_after_err", busy, 0);
    check("short_err_count", n_err - err0, 1);
    check("short_err_cycle", err_cyc, t0 + 5);
    for (int i = 0; i < 20; i++) step(1'b0);
    expect_drained("short");

    // Start pulse during pass 2 is dropped; frame timing unaffected.
    drop0 = n_drop;
    done0 = n_done;
    frame(8, 20, 22, 1'b0, 1, 40);
    expect_drained("drop");
    check("drop_count", n_drop - drop0, 1);
    check("drop_cycle", drop_cyc, t0 + 20);
    check("drop_done_count", n_done - done0, 1);

    // Restart on the final output handshake.
    drop0 = n_drop;
    done0 = n_done;
    frame(8, 37, 45, 1'b1, 1, 78);
    expect_drained("b2b");
    check("b2b_done_count", n_done - done0, 2);
    check("b2b_no_drop", n_drop - drop0, 0);

    // Asynchronous reset mid-frame (during pass 1).
    done0 = n_done;
    err0  = n_err;
    for (int off = 0; off < 14; off++) begin
      step(off < 8);
      if (off == 0) begin
        t0 = cyc;
        push_frame(t0, 8, 1);
      end
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_start = 1'b0;
    load_q.delete();
    issue_q.delete();
    wb_q.delete();
    out_q.delete();
    #1;
    check("midreset_outputs", all_outs, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_no_done", n_done - done0, 0);
    check("midreset_no_err", n_err - err0, 0);
    frame(8, 0, 0, 1'b0, 1, 40);
    expect_drained("after_reset");
    check("after_reset_done_count", n_done - done0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
